// File: rtl/kda_output_arbiter_if.sv
// rtl/kda_output_arbiter_if.sv - core-side and output-side handshake bundle for kda_output_arbiter
//
// Purpose: groups the per-core valid/yumi result handshake and the single held-result
// output handshake into one interface.
// Ports (signals):
//   data_i  [num_cores_p*data_width_p] core results, core k at [k*data_width_p +: data_width_p]
//   v_i     [num_cores_p]              per-core result valid
//   yumi_o  [num_cores_p]              per-core consume, one-hot or zero
//   data_o  [data_width_p]             held result
//   id_o    [id_width_lp]              core index of the held result
//   v_o                                held entry valid
//   yumi_i                             downstream consume
// Modports: master = arbiter side, slave = cores plus downstream consumer side.
interface kda_output_arbiter_if #(
  parameter int num_cores_p  = 4,
  parameter int data_width_p = 1024,
  localparam int id_width_lp = (num_cores_p > 1) ? $clog2(num_cores_p) : 1
);
  logic [num_cores_p*data_width_p-1:0] data_i;
  logic [num_cores_p-1:0]              v_i;
  logic [num_cores_p-1:0]              yumi_o;
  logic [data_width_p-1:0]             data_o;
  logic [id_width_lp-1:0]              id_o;
  logic                                v_o;
  logic                                yumi_i;

  modport master (
    input  data_i, v_i, yumi_i,
    output yumi_o, data_o, id_o, v_o
  );

  modport slave (
    output data_i, v_i, yumi_i,
    input  yumi_o, data_o, id_o, v_o
  );
endinterface

// File: rtl/kda_output_arbiter.sv
// rtl/kda_output_arbiter.sv - round-robin arbiter sharing one output channel among KDA cores
//
// Purpose: grants one requesting core at a time (round-robin starting after the last
// granted core) and captures its result and index into a one-entry output register.
// Ports:
//   clk_i         clock, rising edge
//   reset_i       asynchronous active-high reset
//   enable_i      when low no new grants; a held entry still drains
//   bus_io        kda_output_arbiter_if.master (core and output handshakes)
//   sent_count_o  results delivered downstream, wraps modulo 2^16
module kda_output_arbiter #(
  parameter int num_cores_p  = 4,
  parameter int data_width_p = 1024,
  localparam int id_width_lp = (num_cores_p > 1) ? $clog2(num_cores_p) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       enable_i,
  kda_output_arbiter_if.master       bus_io,
  output logic [15:0]                sent_count_o
);

  localparam logic [id_width_lp-1:0] last_core_lp = id_width_lp'(num_cores_p - 1);

  logic                    full_q, full_d;
  logic [data_width_p-1:0] data_q, data_d;
  logic [id_width_lp-1:0]  id_q, id_d;
  logic [id_width_lp-1:0]  last_q, last_d;
  logic [15:0]             sent_count_q, sent_count_d;

  logic [num_cores_p-1:0]  grant;
  logic [id_width_lp-1:0]  winner;
  logic [id_width_lp-1:0]  cand;
  logic                    found;
  logic [data_width_p-1:0] winner_data;
  logic                    accept;
  logic                    dequeue;

  // Walk all cores once, starting just after the last winner, wrapping at num_cores_p
  // (explicit wrap keeps non-power-of-two core counts correct).
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = last_q;
    for (int off = 0; off < num_cores_p; off++) begin
      cand = (cand == last_core_lp) ? '0 : cand + id_width_lp'(1);
      if (!found && bus_io.v_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    grant         = '0;
    grant[winner] = found;
  end

  always_comb begin
    winner_data = '0;
    for (int k = 0; k < num_cores_p; k++) begin
      if (grant[k]) winner_data = bus_io.data_i[k*data_width_p +: data_width_p];
    end
  end

  // yumi_i only frees the slot when something is actually held; an illegal yumi_i on an
  // empty slot therefore never touches state or the counter. Reset gating keeps yumi_o
  // quiet while reset is held.
  assign dequeue = bus_io.yumi_i & full_q;
  assign accept  = enable_i & ~reset_i & (~full_q | bus_io.yumi_i) & (|bus_io.v_i);

  always_comb begin
    full_d       = full_q;
    data_d       = data_q;
    id_d         = id_q;
    last_d       = last_q;
    sent_count_d = sent_count_q;
    if (dequeue) begin
      full_d       = 1'b0;
      sent_count_d = sent_count_q + 16'd1;
    end
    // A same-cycle accept overrides the dequeue, keeping one result per cycle throughput.
    if (accept) begin
      full_d = 1'b1;
      data_d = winner_data;
      id_d   = winner;
      last_d = winner;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full_q       <= 1'b0;
      data_q       <= '0;
      id_q         <= '0;
      last_q       <= last_core_lp;
      sent_count_q <= '0;
    end else begin
      full_q       <= full_d;
      data_q       <= data_d;
      id_q         <= id_d;
      last_q       <= last_d;
      sent_count_q <= sent_count_d;
    end
  end

  assign bus_io.yumi_o = accept ? grant : '0;
  assign bus_io.v_o    = full_q;
  assign bus_io.data_o = data_q;
  assign bus_io.id_o   = id_q;
  assign sent_count_o  = sent_count_q;

endmodule

// File: doc/kda_output_arbiter.md
# kda_output_arbiter

Round-robin scheduler that shares the single output data channel (1024-bit result in, 64-bit beats out) among `num_cores_p` KDA cores. Each core presents one finished 1024-bit derived-key result with a valid/yumi handshake. The arbiter grants one core at a time and latches its result plus core ID into a one-entry output register. That register drives the output data channel's 1024-bit input port.

## Interface
- `num_cores_p`, default 4: number of requesting cores; must be ≥ 2.
- `data_width_p`, default 1024: result width; must match the output data channel input width.
- `id_width_lp`, derived: `$clog2(num_cores_p)`, minimum 1.
- `clk_i`, in, 1: single clock; all state updates on the rising edge.
- `reset_i`, in, 1: asynchronous, active-high reset.
- `enable_i`, in, 1: when 0, no new grants are issued; a held entry still drains.
- `data_i`, in, `num_cores_p*data_width_p`: core results; core k occupies bits `[k*data_width_p +: data_width_p]`.
- `v_i`, in, `num_cores_p`: per-core result valid.
- `yumi_o`, out, `num_cores_p`: per-core consume; one-hot or zero.
- `data_o`, out, `data_width_p`: held result, to the output data channel `data_i`.
- `id_o`, out, `id_width_lp`: core index of the held result.
- `v_o`, out, 1: held entry valid.
- `yumi_i`, in, 1: downstream consume; legal only while `v_o`=1.
- `sent_count_o`, out, 16: results delivered downstream; wraps modulo 2^16.

## Operation
- State:
  - `full_r`, the single-entry flag.
  - `data_r`.
  - `id_r`.
  - `last_r`: last granted core.
  - `sent_count_r`.
- `v_o` = `full_r`; `data_o` = `data_r`; `id_o` = `id_r`.
- Accept condition: `accept` = `enable_i` & (~`full_r` | `yumi_i`) & (|`v_i`).
- Winner selection when `accept`:
  - Search starts at index (`last_r`+1) mod `num_cores_p` and increases with wrap-around.
  - The first core with `v_i` set wins.
- Actions on `accept`:
  - `yumi_o[winner]`=1 combinationally.
  - At the clock edge: `data_r`←winner data, `id_r`←winner, `last_r`←winner, `full_r`←1.
- If not `accept`:
  - `yumi_o`=0.
  - If `yumi_i`=1, `full_r`←0 at the edge.
  - `data_r` and `id_r` hold their last values.
- Counter: `sent_count_r` increments by 1 on every cycle with `yumi_i`=1; 0xFFFF wraps to 0x0000.
- Simultaneous dequeue and accept in the same cycle:
  - `full_r` stays 1 and the new result replaces the old one.
  - Throughput is one result per cycle.
- `enable_i` falling while full: the entry drains normally. No further grants are issued until `enable_i`=1.
- A core's `v_i` must stay asserted with stable data until it receives `yumi_o`. The arbiter does not require this, but results are undefined otherwise.
- Asserting `yumi_i` while `v_o`=0 is illegal. The bench flags it with an assertion; the RTL ignores it for state updates, and the counter does not increment.

## Timing
- Reset values (asynchronous, immediate):
  - `v_o`=0, `data_o`=0, `id_o`=0, `yumi_o`=0, `sent_count_o`=0.
  - `last_r`=`num_cores_p`−1, so core 0 has first priority after reset.
- Reset asserted mid-operation: the held entry is discarded and not counted. Upstream cores see no `yumi_o` during reset.
- Latency: `v_i[k]` rising in cycle t with the arbiter empty and enabled gives `yumi_o[k]`=1 in cycle t and `v_o`=1 with `id_o`=k in cycle t+1.
- Combinational path `yumi_i` → `yumi_o` exists and is intentional. Downstream `yumi_i` must be a registered or ready&valid-derived signal, which is satisfied by the output data channel.
- No combinational path from `v_i` to `v_o`, `data_o` or `id_o`.
- Fairness: with all cores continuously requesting, grants cycle 0,1,…,`num_cores_p`−1,0,…. No core waits more than `num_cores_p`−1 grants.

## Test plan
- Single requester:
  - Reset, `enable_i`=1, only `v_i`=4'b0100 with data 0xA5… (repeated).
  - `yumi_o`=4'b0100 in the same cycle.
  - Next cycle `v_o`=1, `id_o`=2, `data_o`=0xA5….
  - `yumi_i` pulse → `v_o`=0 and `sent_count_o`=1.
- Full round-robin:
  - `v_i`=4'b1111 held and `yumi_i`=1 whenever `v_o`=1; run 8 grants.
  - `id_o` sequence is 0,1,2,3,0,1,2,3; `sent_count_o`=8.
- Backpressure:
  - `v_i`=4'b0011, `yumi_i`=0 for 5 cycles after the first capture.
  - `id_o`=0 stays stable and `yumi_o`=0 throughout.
  - When `yumi_i`=1, core 1 is granted in the same cycle and `id_o`=1 the next cycle.
- Enable gating:
  - `enable_i`=0 with `v_i`=4'b1000 → `yumi_o`=0 and `v_o`=0 indefinitely.
  - `enable_i`→1 → grant to core 3 that cycle.
- Wrap and reset:
  - Preload by sending 65,537 results → `sent_count_o`=1.
  - Assert `reset_i` asynchronously while `v_o`=1 → `v_o`, `sent_count_o` and `yumi_o` go to 0 immediately.
  - After release, the first grant goes to core 0 when `v_i`=4'b1111.
